bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter in front of `bus_interconnect`: shares the single data-bus port (address, write data, write enable, read data) between master 0 (core load/store unit) and master 1 (DMA/debug loader). One transfer is granted per cycle and read data is routed back to the master that issued the read. Arbitration is fixed-priority or round-robin, and either master may lock the bus.

## Interface
- `WIDTH`, 32, address/data width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `m0_req`, `m1_req`  in  1  transfer request.
- `m0_addr`, `m1_addr`  in  WIDTH  byte address.
- `m0_wdata`, `m1_wdata`  in  WIDTH  write data.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_lock`, `m1_lock`  in  1  hold ownership after the current grant.
- `m0_gnt`, `m1_gnt`  out  1  request accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1  read data valid for this master.
- `m0_rdata`, `m1_rdata`  out  WIDTH  read data, both driven from `rdata`.
- `addr`  out  WIDTH  downstream address.
- `wdata`  out  WIDTH  downstream write data.
- `we`  out  1  downstream write enable.
- `rdata`  in  WIDTH  downstream read data, valid 1 cycle after the address.

## Operation
- A transfer completes in the cycle where `mX_req & mX_gnt` is high. At most one `gnt` is high per cycle. A grant is only given to a requesting master.
- The downstream `addr`, `wdata` and `we` follow the granted master. When nothing is granted, `addr` and `wdata` hold the master 0 values and `we = 0`.
- Lock FSM states:
  - UNLOCKED: normal arbitration.
  - LOCK0: master 0 is granted exclusively while `m0_req` is high.
  - LOCK1: master 1 is granted exclusively while `m1_req` is high.
- Lock FSM transitions:
  - UNLOCKED → LOCKx when master x is granted with `mx_lock = 1`.
  - LOCKx → UNLOCKED when master x is granted with `mx_lock = 0`, or when `mx_lock = 0` while no request is pending.
  - In LOCKx, the other master gets `gnt = 0` even if master x is idle.
- Read return:
  - Registered `rd_owner` and `rd_pend` are captured every cycle from the granted read.
  - Next cycle, `mX_rvalid = rd_pend & (rd_owner == X)`.
- Writes produce no response.
- Read and write accesses are back-to-back capable: one new grant can be issued every cycle while the previous read returns.
- If both masters request in the same cycle, the policy decides (see Configuration). The loser sees `gnt = 0` and must hold its request stable until granted.
- On `rst`: FSM returns to UNLOCKED, `rd_pend = 0`, `last_gnt = 1` (so master 0 wins first under round-robin).
- During the reset cycle all `gnt`, `rvalid` and `we` are 0. A read granted in the cycle before reset asserts produces no `rvalid`.

## Timing
- Grant latency: 0 cycles. `gnt` depends combinationally on `req`, the FSM state and `last_gnt`.
- Read latency: 1 cycle from the grant cycle to `rvalid`. This matches the registered select in `bus_interconnect`.
- `rvalid` lasts exactly 1 cycle per granted read.
- `rdata` is passed through combinationally to both `mX_rdata`. Masters must qualify it with their own `rvalid`.
- Maximum throughput is 1 transfer per cycle total.
- Under round-robin, each of two continuously requesting masters gets a grant at least every 2 cycles, unless the other master holds a lock.

## Configuration
- `BUS_ARBITER_RR_EN` defined: round-robin.
  - On contention, the master not granted last (`last_gnt`) wins.
  - `last_gnt` updates on every grant.
- Not defined: fixed priority, master 0 always wins contention.
  - The `last_gnt` register is not implemented.
  - Master 1 may starve.
- The lock FSM and read routing are identical in both builds.

## Structure
- Shared package `bus_pkg` holds:
  - `typedef enum logic [1:0] {UNLOCKED, LOCK0, LOCK1} bus_lock_e`.
  - `localparam logic M0 = 1'b0, M1 = 1'b1` for master IDs.
  - The GPIO region code `4'd2`, shared with `bus_interconnect`.
- One natural sub-module, `bus_arb_pick`: a combinational 2-way picker taking `req[1:0]`, `last_gnt` and the lock state, and producing `gnt[1:0]`. Its policy is selected by `BUS_ARBITER_RR_EN`.

## Test plan
- Reset, then `m0_req = 1` reading `addr 0x0000_0010` with RAM returning `0xDEADBEEF` → `m0_gnt = 1` at cycle 0; `m0_rvalid = 1` and `m0_rdata = 0xDEADBEEF` at cycle 1; `m1_rvalid = 0`.
- Both masters request reads continuously for 6 cycles, RR build → grant sequence 0,1,0,1,0,1 and `rvalid` alternates one cycle later. Fixed build → master 0 granted all 6 cycles, `m1_gnt` always 0.
- `m1` writes `0x2000_0000 = 0x5` with `m1_lock = 1` for 3 transfers while `m0_req = 1` → `m1_gnt` on 3 cycles; `m0_gnt = 0` until the cycle after `m1` drops `lock`.
- Master 0 reads in cycle N, master 1 writes in cycle N+1 → `we = 1` with `m1_addr` in N+1, and `m0_rvalid` high in N+1 with `m1_rvalid = 0`.
- Read granted in cycle N, `rst` asserted in cycle N+1 → no `rvalid` in N+1, FSM in UNLOCKED, first grant after reset goes to master 0.
- No requests for 4 cycles → `we = 0`, both `gnt = 0`, both `rvalid = 0`.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: lock-state encoding, master IDs and region codes.
// Used by bus_arbiter (build option BUS_ARBITER_RR_EN) and bus_interconnect.
package bus_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCK0,
    LOCK1
  } bus_lock_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [3:0] REGION_GPIO = 4'd2;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational 2-way grant picker; round-robin when BUS_ARBITER_RR_EN is
// defined, fixed priority (master 0 wins) otherwise.
module bus_arb_pick
  import bus_pkg::*;
(
  input  logic [1:0] req,
`ifdef BUS_ARBITER_RR_EN
  input  logic       last_gnt,
`endif
  input  bus_lock_e  lock_st,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (lock_st)
      // A lock owner keeps the bus even while idle; the other master waits.
      LOCK0: gnt = {1'b0, req[0]};
      LOCK1: gnt = {req[1], 1'b0};
      default: begin
        if (req == 2'b11) begin
`ifdef BUS_ARBITER_RR_EN
          gnt = (last_gnt == M0) ? 2'b10 : 2'b01;
`else
          gnt = 2'b01;
`endif
        end else begin
          gnt = req;
        end
      end
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with lock FSM and 1-cycle read-return routing.
// Define BUS_ARBITER_RR_EN for round-robin; default build is fixed priority.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  input  logic [WIDTH-1:0] m1_wdata,
  input  logic             m0_we,
  input  logic             m1_we,
  input  logic             m0_lock,
  input  logic             m1_lock,
  output logic             m0_gnt,
  output logic             m1_gnt,
  output logic             m0_rvalid,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  output logic [WIDTH-1:0] m1_rdata,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] wdata,
  output logic             we,
  input  logic [WIDTH-1:0] rdata
);

  bus_lock_e  lock_st;
  logic       rd_pend;
  logic       rd_owner;
  logic [1:0] req;
  logic [1:0] pick_gnt;
  logic [1:0] gnt;
  logic       rd_xfer;
`ifdef BUS_ARBITER_RR_EN
  logic       last_gnt;
`endif

  assign req = {m1_req, m0_req};

  bus_arb_pick u_pick (
    .req      (req),
`ifdef BUS_ARBITER_RR_EN
    .last_gnt (last_gnt),
`endif
    .lock_st  (lock_st),
    .gnt      (pick_gnt)
  );

  // Nothing is granted while reset is held.
  assign gnt    = rst ? 2'b00 : pick_gnt;
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    addr  = m0_addr;
    wdata = m0_wdata;
    we    = 1'b0;
    if (gnt[1]) begin
      addr  = m1_addr;
      wdata = m1_wdata;
      we    = m1_we;
    end else if (gnt[0]) begin
      we = m0_we;
    end
  end

  assign rd_xfer = (gnt[0] & ~m0_we) | (gnt[1] & ~m1_we);

  // Grant stage -> read-return stage
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_st <= UNLOCKED;
      rd_pend <= 1'b0;
`ifdef BUS_ARBITER_RR_EN
      last_gnt <= M1;
`endif
    end else begin
      rd_pend <= rd_xfer;
`ifdef BUS_ARBITER_RR_EN
      if (gnt != 2'b00) begin
        last_gnt <= gnt[1] ? M1 : M0;
      end
`endif
      case (lock_st)
        UNLOCKED: begin
          if (gnt[0] && m0_lock) begin
            lock_st <= LOCK0;
          end else if (gnt[1] && m1_lock) begin
            lock_st <= LOCK1;
          end
        end
        LOCK0: begin
          if (!m0_lock && (gnt[0] || !m0_req)) begin
            lock_st <= UNLOCKED;
          end
        end
        LOCK1: begin
          if (!m1_lock && (gnt[1] || !m1_req)) begin
            lock_st <= UNLOCKED;
          end
        end
        default: lock_st <= UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    rd_owner <= gnt[1] ? M1 : M0;
  end

  // The reset gate drops a read-return whose grant came just before reset.
  assign m0_rvalid = ~rst & rd_pend & (rd_owner == M0);
  assign m1_rvalid = ~rst & rd_pend & (rd_owner == M1);
  assign m0_rdata  = rdata;
  assign m1_rdata  = rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a cycle-level reference model.
// Honours BUS_ARBITER_RR_EN the same way as the design.
module tb_bus_arbiter;

`ifdef BUS_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_we, m1_we, m0_lock, m1_lock;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] addr, wdata;
  logic        we;
  logic [31:0] rdata = 32'h0;
  logic [31:0] ram_addr_q;

  int vectors = 0;
  int miscompares = 0;

  bus_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_val(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_5A5A);
  endfunction

  // Downstream RAM: data for the address seen at an edge appears one cycle later.
  always @(posedge clk) begin
    ram_addr_q = addr;
    #1 rdata = ram_val(ram_addr_q);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: lock owner (-1 none), last granted master, pending read.
  int          md_lock = -1;
  int          md_last = 1;
  bit          md_pv = 1'b0;
  int          md_pw = 0;
  logic [31:0] md_pa = 32'h0;
  int          md_w;
  logic [31:0] md_ea, md_ewd;
  bit          md_ewe, md_rv0, md_rv1;

  always @(negedge clk) begin
    md_w = -1;
    if (!rst) begin
      if (md_lock == 0)      md_w = m0_req ? 0 : -1;
      else if (md_lock == 1) md_w = m1_req ? 1 : -1;
      else if (m0_req && m1_req) md_w = RR ? ((md_last == 0) ? 1 : 0) : 0;
      else if (m0_req)       md_w = 0;
      else if (m1_req)       md_w = 1;
    end
    md_ea  = (md_w == 1) ? m1_addr : m0_addr;
    md_ewd = (md_w == 1) ? m1_wdata : m0_wdata;
    md_ewe = (md_w == 0) ? m0_we : (md_w == 1) ? m1_we : 1'b0;
    md_rv0 = !rst && md_pv && (md_pw == 0);
    md_rv1 = !rst && md_pv && (md_pw == 1);

    chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, md_w == 0});
    chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, md_w == 1});
    chk("addr", addr, md_ea);
    chk("wdata", wdata, md_ewd);
    chk("we", {31'd0, we}, {31'd0, md_ewe});
    chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, md_rv0});
    chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, md_rv1});
    chk("m0_rdata", m0_rdata, rdata);
    chk("m1_rdata", m1_rdata, rdata);
    if (md_rv0 || md_rv1) chk("rdata_ret", rdata, ram_val(md_pa));

    if (rst) begin
      md_lock = -1;
      md_last = 1;
      md_pv   = 1'b0;
    end else begin
      md_pv = (md_w >= 0) && !md_ewe;
      md_pw = md_w;
      md_pa = md_ea;
      if (md_lock < 0) begin
        if (md_w == 0 && m0_lock)      md_lock = 0;
        else if (md_w == 1 && m1_lock) md_lock = 1;
      end else if (md_lock == 0) begin
        if (!m0_lock && (md_w == 0 || !m0_req)) md_lock = -1;
      end else begin
        if (!m1_lock && (md_w == 1 || !m1_req)) md_lock = -1;
      end
      if (md_w >= 0) md_last = md_w;
    end
  end

  task automatic drive(input logic r0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic w0, input logic l0,
                       input logic r1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic w1, input logic l1);
    m0_req = r0; m0_addr = a0; m0_wdata = d0; m0_we = w0; m0_lock = l0;
    m1_req = r1; m1_addr = a1; m1_wdata = d1; m1_we = w1; m1_lock = l1;
  endtask

  task automatic idle();
    drive(0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    // Requests during reset must still be refused.
    drive(1, 32'h10, 32'h1, 1, 1, 1, 32'h20, 32'h2, 1, 1);
    tick();
    @(negedge clk);
    chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    tick();

    // Single read by master 0.
    rst = 1'b0;
    drive(1, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    chk("t1_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("t1_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("t1_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("t1_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    tick();

    // Contention from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 32'h100, 32'h0, 0, 0, 1, 32'h200, 32'h0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_m0_gnt", {31'd0, m0_gnt}, RR ? {31'd0, (i % 2) == 0} : 32'd1);
      chk("t2_m1_gnt", {31'd0, m1_gnt}, RR ? {31'd0, (i % 2) == 1} : 32'd0);
      if (i > 0) chk("t2_m1_rvalid", {31'd0, m1_rvalid}, RR ? {31'd0, (i % 2) == 0} : 32'd0);
      tick();
    end
    idle();
    tick();

    // Master 1 locks the bus for three writes while master 0 waits.
    drive(0, 32'h0, 32'h0, 0, 0, 1, 32'h2000_0000, 32'h5, 1, 1);
    @(negedge clk);
    chk("t3_m1_gnt_a", {31'd0, m1_gnt}, 32'd1);
    tick();
    drive(1, 32'h44, 32'h0, 0, 0, 1, 32'h2000_0000, 32'h5, 1, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t3_m1_gnt", {31'd0, m1_gnt}, 32'd1);
      chk("t3_m0_gnt", {31'd0, m0_gnt}, 32'd0);
      chk("t3_addr", addr, 32'h2000_0000);
      chk("t3_wdata", wdata, 32'h5);
      chk("t3_we", {31'd0, we}, 32'd1);
      tick();
    end
    drive(1, 32'h44, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    chk("t3_m0_gnt_drop", {31'd0, m0_gnt}, 32'd0);
    tick();
    @(negedge clk);
    chk("t3_m0_gnt_after", {31'd0, m0_gnt}, 32'd1);
    tick();
    idle();
    tick();

    // Master 0 read then master 1 write back-to-back.
    drive(1, 32'h40, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0, 1, 32'h3000_0004, 32'h77, 1, 0);
    @(negedge clk);
    chk("t4_we", {31'd0, we}, 32'd1);
    chk("t4_addr", addr, 32'h3000_0004);
    chk("t4_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("t4_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("t4_rdata", m0_rdata, ram_val(32'h40));
    tick();
    idle();
    tick();

    // Locked read by master 1, then reset in the following cycle.
    drive(0, 32'h0, 32'h0, 0, 0, 1, 32'h80, 32'h0, 0, 1);
    @(negedge clk);
    chk("t5_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    tick();
    rst = 1'b1;
    drive(1, 32'h84, 32'h0, 0, 0, 1, 32'h88, 32'h0, 0, 1);
    @(negedge clk);
    chk("t5_rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("t5_rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_first_m0", {31'd0, m0_gnt}, 32'd1);
    chk("t5_first_m1", {31'd0, m1_gnt}, 32'd0);
    tick();
    idle();
    tick();

    // Quiet bus.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
      chk("t6_we", {31'd0, we}, 32'd0);
      chk("t6_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      tick();
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
